// File: rtl/cpu_ctl_pkg.sv
// Shared definitions for the multi-cycle CPU control FSM.
//   - opcode constants for the supported instruction set
//   - ALU operation codes and datapath mux select constants
//   - FSM state encoding (4-bit binary)
//   - ctl_t: the bundle of datapath strobes produced for each state
//   - op_known(): true for opcodes the control unit can execute
package cpu_ctl_pkg;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 3;

  // Opcodes (IR[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  // ALU operation codes
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b100;

  // ALU B input select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FSM states; encodings 13..15 are unreachable and recover to S_IDLE.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXE_R   = 4'd3,
    S_WB_R    = 4'd4,
    S_EXE_I   = 4'd5,
    S_WB_I    = 4'd6,
    S_MEM_ADR = 4'd7,
    S_MEM_RD  = 4'd8,
    S_MEM_WB  = 4'd9,
    S_MEM_WR  = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  // Datapath strobes driven from the current state.
  typedef struct packed {
    logic               pc_write;
    logic               ir_write;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               ext_op;
    logic [1:0]         pc_src;
  } ctl_t;

  function automatic logic op_known(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_ORI) || (op == OP_LW) ||
           (op == OP_SW)    || (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/ctl_out_decode.sv
// Combinational strobe decode for the multi-cycle control FSM.
// Ports:
//   state      in   current FSM state
//   zero       in   ALU zero flag (branch decision in S_BRANCH)
//   mem_ready  in   memory completes its access this cycle (fetch commit)
//   ctl        out  datapath strobe bundle
// Every strobe defaults to 0; each state only raises what it needs, so
// S_IDLE and any unreachable encoding produce an all-zero bundle.
module ctl_out_decode
  import cpu_ctl_pkg::*;
(
  input  state_t state,
  input  logic   zero,
  input  logic   mem_ready,
  output ctl_t   ctl
);

  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.i_or_d    = 1'b0;
        ctl.alu_src_a = 1'b0;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALUOP_ADD;
        ctl.pc_src    = PCSRC_ALU;
        // PC+4 and the IR load commit together, only when the word arrives.
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Precompute the branch target PC + (sext(imm) << 2) into ALUOut.
        ctl.alu_src_a = 1'b0;
        ctl.alu_src_b = SRCB_IMM_SH;
        ctl.ext_op    = 1'b1;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_EXE_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_RT;
        ctl.alu_op    = ALUOP_FUNCT;
      end
      S_WB_R: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b1;
        ctl.mem_to_reg = 1'b0;
      end
      S_EXE_I: begin
        // ori zero-extends its immediate.
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.ext_op    = 1'b0;
        ctl.alu_op    = ALUOP_OR;
      end
      S_WB_I: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b0;
        ctl.mem_to_reg = 1'b0;
      end
      S_MEM_ADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.ext_op    = 1'b1;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b0;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        // Held for the whole wait; memory commits on the mem_ready cycle.
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_RT;
        ctl.alu_op    = ALUOP_SUB;
        ctl.pc_src    = PCSRC_ALUOUT;
        ctl.pc_write  = zero;
      end
      S_JUMP: begin
        ctl.pc_src   = PCSRC_JUMP;
        ctl.pc_write = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Moore control FSM for the multi-cycle CPU datapath.
// Supports R-type, ori, lw, sw, beq and j; unknown opcodes are executed as
// a NOP (FETCH, DECODE, back to FETCH) with a one-cycle illegal_op pulse.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   op                  IR opcode, only looked at in S_DECODE
//   zero                ALU zero flag for beq
//   mem_ready           memory access completes this cycle
//   pc_write .. pc_src  datapath strobes (see ctl_out_decode)
//   illegal_op          pulse in S_DECODE for an unknown opcode
//   state_o             current state encoding, for debug
// Memory handshake: a request (mem_read or mem_write) is held constant
// while mem_ready is 0; the cycle in which mem_ready is 1 is the single
// cycle the access completes, and the FSM leaves the state on that edge.
module multi_cycle_control
  import cpu_ctl_pkg::*;
#(
  parameter int OP_W_P    = OP_W,
  parameter int ALUOP_W_P = ALUOP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_W_P-1:0]    op,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALUOP_W_P-1:0] alu_op,
  output logic                 ext_op,
  output logic [1:0]           pc_src,
  output logic                 illegal_op,
  output logic [3:0]           state_o
);

  state_t state_q;
  state_t state_d;
  // Remembers lw vs sw from S_DECODE so S_MEM_ADR does not depend on op,
  // which the datapath may change once decode is over.
  logic   is_sw_q;
  ctl_t   ctl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        is_sw_q <= (op == OP_SW);
      end
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE: state_d = S_EXE_R;
          OP_ORI:   state_d = S_EXE_I;
          OP_LW:    state_d = S_MEM_ADR;
          OP_SW:    state_d = S_MEM_ADR;
          OP_BEQ:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
          default:  state_d = S_FETCH;
        endcase
      end
      S_EXE_R:   state_d = S_WB_R;
      S_WB_R:    state_d = S_FETCH;
      S_EXE_I:   state_d = S_WB_I;
      S_WB_I:    state_d = S_FETCH;
      S_MEM_ADR: state_d = is_sw_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:  state_d = S_FETCH;
      S_MEM_WR:  state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  ctl_out_decode u_decode (
    .state     (state_q),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctl       (ctl)
  );

  assign pc_write   = ctl.pc_write;
  assign ir_write   = ctl.ir_write;
  assign i_or_d     = ctl.i_or_d;
  assign mem_read   = ctl.mem_read;
  assign mem_write  = ctl.mem_write;
  assign mem_to_reg = ctl.mem_to_reg;
  assign reg_dst    = ctl.reg_dst;
  assign reg_write  = ctl.reg_write;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign alu_op     = ctl.alu_op;
  assign ext_op     = ctl.ext_op;
  assign pc_src     = ctl.pc_src;

  assign illegal_op = (state_q == S_DECODE) && !op_known(op);
  assign state_o    = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control. Each scenario task walks a table
// of per-cycle rows {rst, mem_ready, zero, op, expected state, expected
// strobes}; inputs are driven just after the rising edge and outputs are
// compared on the falling edge.
module tb_multi_cycle_control;
  import cpu_ctl_pkg::*;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       ext_op;
  logic [1:0] pc_src;
  logic       illegal_op;
  logic [3:0] state_o;

  int total;
  int bad;
  logic chk_en;

  // {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
  //  reg_write, alu_src_a, alu_src_b[1:0], alu_op[2:0], ext_op, pc_src[1:0],
  //  illegal_op}
  logic [17:0] obs;
  assign obs = {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, ext_op,
                pc_src, illegal_op};

  localparam logic [17:0] V_ZERO     = 18'b000000000_00_000_0_00_0;
  localparam logic [17:0] V_FETCH_W  = 18'b000100000_01_000_0_00_0;
  localparam logic [17:0] V_FETCH_R  = 18'b110100000_01_000_0_00_0;
  localparam logic [17:0] V_DECODE   = 18'b000000000_11_000_1_00_0;
  localparam logic [17:0] V_DEC_ILL  = 18'b000000000_11_000_1_00_1;
  localparam logic [17:0] V_EXE_R    = 18'b000000001_00_100_0_00_0;
  localparam logic [17:0] V_WB_R     = 18'b000000110_00_000_0_00_0;
  localparam logic [17:0] V_EXE_I    = 18'b000000001_10_010_0_00_0;
  localparam logic [17:0] V_WB_I     = 18'b000000010_00_000_0_00_0;
  localparam logic [17:0] V_MEM_ADR  = 18'b000000001_10_000_1_00_0;
  localparam logic [17:0] V_MEM_RD   = 18'b001100000_00_000_0_00_0;
  localparam logic [17:0] V_MEM_WB   = 18'b000001010_00_000_0_00_0;
  localparam logic [17:0] V_MEM_WR   = 18'b001010000_00_000_0_00_0;
  localparam logic [17:0] V_BR_T     = 18'b100000001_00_001_0_01_0;
  localparam logic [17:0] V_BR_N     = 18'b000000001_00_001_0_01_0;
  localparam logic [17:0] V_JUMP     = 18'b100000000_00_000_0_10_0;

  multi_cycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .ext_op     (ext_op),
    .pc_src     (pc_src),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exclusive strobe pairs, checked every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (mem_read && mem_write) begin
        bad++;
        $display("FAIL excl_mem t=%0t: mem_read=%b mem_write=%b, required not both 1",
                 $time, mem_read, mem_write);
      end
      total++;
      if (reg_write && pc_write) begin
        bad++;
        $display("FAIL excl_wr t=%0t: reg_write=%b pc_write=%b, required not both 1",
                 $time, reg_write, pc_write);
      end
    end
  end

  // Row layout: [30] rst, [29] mem_ready, [28] zero, [27:22] op,
  //             [21:18] expected state, [17:0] expected strobes.
  task automatic test_reset();
    logic [30:0] rows [3];
    rows = '{
      {1'b1, 1'b0, 1'b0, 6'b000000, S_IDLE, V_ZERO},
      {1'b1, 1'b1, 1'b1, 6'b111111, S_IDLE, V_ZERO},
      {1'b0, 1'b0, 1'b0, 6'b000000, S_IDLE, V_ZERO}
    };
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    foreach (rows[i]) begin
      {rst, mem_ready, zero, op} = rows[i][30:22];
      @(negedge clk);
      total++;
      if (state_o !== rows[i][21:18]) begin
        bad++;
        $display("FAIL reset[%0d] state: got %0d, required %0d", i, state_o, rows[i][21:18]);
      end
      total++;
      if (obs !== rows[i][17:0]) begin
        bad++;
        $display("FAIL reset[%0d] strobes: got %b, required %b", i, obs, rows[i][17:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype_ori();
    logic [30:0] rows [8];
    rows = '{
      {1'b0, 1'b1, 1'b0, 6'b000000, S_FETCH,  V_FETCH_R},
      {1'b0, 1'b1, 1'b0, 6'b000000, S_DECODE, V_DECODE},
      {1'b0, 1'b1, 1'b1, 6'b101011, S_EXE_R,  V_EXE_R},
      {1'b0, 1'b0, 1'b0, 6'b101011, S_WB_R,   V_WB_R},
      {1'b0, 1'b1, 1'b0, 6'b000000, S_FETCH,  V_FETCH_R},
      {1'b0, 1'b1, 1'b0, 6'b001101, S_DECODE, V_DECODE},
      {1'b0, 1'b1, 1'b0, 6'b000100, S_EXE_I,  V_EXE_I},
      {1'b0, 1'b1, 1'b0, 6'b000100, S_WB_I,   V_WB_I}
    };
    foreach (rows[i]) begin
      {rst, mem_ready, zero, op} = rows[i][30:22];
      @(negedge clk);
      total++;
      if (state_o !== rows[i][21:18]) begin
        bad++;
        $display("FAIL rtype_ori[%0d] state: got %0d, required %0d", i, state_o, rows[i][21:18]);
      end
      total++;
      if (obs !== rows[i][17:0]) begin
        bad++;
        $display("FAIL rtype_ori[%0d] strobes: got %b, required %b", i, obs, rows[i][17:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  // lw with 2 fetch waits and 3 read waits: 10 cycles. op switches to the
  // sw opcode after decode to show the lw/sw class was latched.
  task automatic test_lw_waits();
    logic [30:0] rows [10];
    rows = '{
      {1'b0, 1'b0, 1'b0, 6'b100011, S_FETCH,   V_FETCH_W},
      {1'b0, 1'b0, 1'b0, 6'b100011, S_FETCH,   V_FETCH_W},
      {1'b0, 1'b1, 1'b0, 6'b100011, S_FETCH,   V_FETCH_R},
      {1'b0, 1'b0, 1'b0, 6'b100011, S_DECODE,  V_DECODE},
      {1'b0, 1'b0, 1'b0, 6'b101011, S_MEM_ADR, V_MEM_ADR},
      {1'b0, 1'b0, 1'b0, 6'b101011, S_MEM_RD,  V_MEM_RD},
      {1'b0, 1'b0, 1'b1, 6'b101011, S_MEM_RD,  V_MEM_RD},
      {1'b0, 1'b0, 1'b0, 6'b101011, S_MEM_RD,  V_MEM_RD},
      {1'b0, 1'b1, 1'b0, 6'b101011, S_MEM_RD,  V_MEM_RD},
      {1'b0, 1'b0, 1'b0, 6'b101011, S_MEM_WB,  V_MEM_WB}
    };
    foreach (rows[i]) begin
      {rst, mem_ready, zero, op} = rows[i][30:22];
      @(negedge clk);
      total++;
      if (state_o !== rows[i][21:18]) begin
        bad++;
        $display("FAIL lw_waits[%0d] state: got %0d, required %0d", i, state_o, rows[i][21:18]);
      end
      total++;
      if (obs !== rows[i][17:0]) begin
        bad++;
        $display("FAIL lw_waits[%0d] strobes: got %b, required %b", i, obs, rows[i][17:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    logic [30:0] rows [6];
    rows = '{
      {1'b0, 1'b1, 1'b0, 6'b000100, S_FETCH,  V_FETCH_R},
      {1'b0, 1'b1, 1'b0, 6'b000100, S_DECODE, V_DECODE},
      {1'b0, 1'b1, 1'b1, 6'b000100, S_BRANCH, V_BR_T},
      {1'b0, 1'b1, 1'b1, 6'b000100, S_FETCH,  V_FETCH_R},
      {1'b0, 1'b1, 1'b1, 6'b000100, S_DECODE, V_DECODE},
      {1'b0, 1'b1, 1'b0, 6'b000100, S_BRANCH, V_BR_N}
    };
    foreach (rows[i]) begin
      {rst, mem_ready, zero, op} = rows[i][30:22];
      @(negedge clk);
      total++;
      if (state_o !== rows[i][21:18]) begin
        bad++;
        $display("FAIL beq[%0d] state: got %0d, required %0d", i, state_o, rows[i][21:18]);
      end
      total++;
      if (obs !== rows[i][17:0]) begin
        bad++;
        $display("FAIL beq[%0d] strobes: got %b, required %b", i, obs, rows[i][17:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  // sw (op switched to lw after decode, mem_ready low twice), then j.
  task automatic test_sw_j();
    logic [30:0] rows [9];
    rows = '{
      {1'b0, 1'b1, 1'b0, 6'b101011, S_FETCH,   V_FETCH_R},
      {1'b0, 1'b1, 1'b0, 6'b101011, S_DECODE,  V_DECODE},
      {1'b0, 1'b1, 1'b0, 6'b100011, S_MEM_ADR, V_MEM_ADR},
      {1'b0, 1'b0, 1'b0, 6'b100011, S_MEM_WR,  V_MEM_WR},
      {1'b0, 1'b0, 1'b0, 6'b100011, S_MEM_WR,  V_MEM_WR},
      {1'b0, 1'b1, 1'b0, 6'b100011, S_MEM_WR,  V_MEM_WR},
      {1'b0, 1'b1, 1'b0, 6'b000010, S_FETCH,   V_FETCH_R},
      {1'b0, 1'b1, 1'b0, 6'b000010, S_DECODE,  V_DECODE},
      {1'b0, 1'b1, 1'b1, 6'b000000, S_JUMP,    V_JUMP}
    };
    foreach (rows[i]) begin
      {rst, mem_ready, zero, op} = rows[i][30:22];
      @(negedge clk);
      total++;
      if (state_o !== rows[i][21:18]) begin
        bad++;
        $display("FAIL sw_j[%0d] state: got %0d, required %0d", i, state_o, rows[i][21:18]);
      end
      total++;
      if (obs !== rows[i][17:0]) begin
        bad++;
        $display("FAIL sw_j[%0d] strobes: got %b, required %b", i, obs, rows[i][17:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [30:0] rows [4];
    rows = '{
      {1'b0, 1'b1, 1'b0, 6'b111111, S_FETCH,  V_FETCH_R},
      {1'b0, 1'b1, 1'b0, 6'b111111, S_DECODE, V_DEC_ILL},
      {1'b0, 1'b1, 1'b0, 6'b000001, S_FETCH,  V_FETCH_R},
      {1'b0, 1'b1, 1'b0, 6'b000001, S_DECODE, V_DEC_ILL}
    };
    foreach (rows[i]) begin
      {rst, mem_ready, zero, op} = rows[i][30:22];
      @(negedge clk);
      total++;
      if (state_o !== rows[i][21:18]) begin
        bad++;
        $display("FAIL illegal[%0d] state: got %0d, required %0d", i, state_o, rows[i][21:18]);
      end
      total++;
      if (obs !== rows[i][17:0]) begin
        bad++;
        $display("FAIL illegal[%0d] strobes: got %b, required %b", i, obs, rows[i][17:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset asserted for 2 cycles while waiting in S_MEM_RD with mem_ready=1.
  task automatic test_reset_mid();
    logic [30:0] rows [9];
    rows = '{
      {1'b0, 1'b1, 1'b0, 6'b100011, S_FETCH,   V_FETCH_R},
      {1'b0, 1'b1, 1'b0, 6'b100011, S_DECODE,  V_DECODE},
      {1'b0, 1'b1, 1'b0, 6'b100011, S_MEM_ADR, V_MEM_ADR},
      {1'b0, 1'b0, 1'b0, 6'b100011, S_MEM_RD,  V_MEM_RD},
      {1'b1, 1'b1, 1'b0, 6'b100011, S_MEM_RD,  V_MEM_RD},
      {1'b1, 1'b1, 1'b0, 6'b100011, S_IDLE,    V_ZERO},
      {1'b0, 1'b1, 1'b0, 6'b100011, S_IDLE,    V_ZERO},
      {1'b0, 1'b0, 1'b0, 6'b100011, S_FETCH,   V_FETCH_W},
      {1'b0, 1'b0, 1'b0, 6'b100011, S_FETCH,   V_FETCH_W}
    };
    foreach (rows[i]) begin
      {rst, mem_ready, zero, op} = rows[i][30:22];
      @(negedge clk);
      total++;
      if (state_o !== rows[i][21:18]) begin
        bad++;
        $display("FAIL reset_mid[%0d] state: got %0d, required %0d", i, state_o, rows[i][21:18]);
      end
      total++;
      if (obs !== rows[i][17:0]) begin
        bad++;
        $display("FAIL reset_mid[%0d] strobes: got %b, required %b", i, obs, rows[i][17:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    chk_en = 1'b0;
    rst = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_rtype_ori();
    test_lw_waits();
    test_beq();
    test_sw_j();
    test_illegal();
    test_reset_mid();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
